// File: rtl/switch_irq_pkg.sv
// Shared register map, control bit positions and debounce depth for switch_irq.
package switch_irq_pkg;

  // Byte offsets of the 32-bit registers (bits [1:0] select the lane)
  localparam logic [3:0] ADDR_STATE = 4'h0;
  localparam logic [3:0] ADDR_EDGE  = 4'h4;
  localparam logic [3:0] ADDR_MASK  = 4'h8;
  localparam logic [3:0] ADDR_CTRL  = 4'hC;

  // CTRL register bit positions
  localparam int CTRL_RISE_EN = 0;
  localparam int CTRL_FALL_EN = 1;
  localparam int CTRL_PRIMED  = 7;

  // Consecutive equal tick samples needed to accept a new switch level
  localparam int DEBOUNCE_SAMPLES = 3;

  // Register base offset of a byte address (lane bits cleared)
  function automatic logic [3:0] reg_base(input logic [3:0] adr);
    return {adr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: two-flop synchroniser, tick-sampled shift window, debounced
// level and single-cycle rise/fall pulses.
module switch_debounce
  import switch_irq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic primed,
  input  logic raw,
  output logic state_o,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0]                  sync_q;
  logic [DEBOUNCE_SAMPLES-1:0] samples_q;
  logic [DEBOUNCE_SAMPLES-1:0] samples_d;
  logic                        state_q;
  logic                        agree;
  logic                        change;

  // Window as it will be after this tick: newest sample enters at bit 0
  assign samples_d = {samples_q[DEBOUNCE_SAMPLES-2:0], sync_q[1]};
  assign agree     = (samples_d == '0) || (samples_d == '1);
  // Before priming the load is unconditional, so only the event pulses
  // below look at primed; the level update itself is the same either way.
  assign change    = tick && agree && (state_q != samples_d[0]);

  assign state_o  = state_q;
  assign stable_o = agree;
  assign rise_o   = change && primed && samples_d[0];
  assign fall_o   = change && primed && !samples_d[0];

  // Two-flop synchroniser for the asynchronous switch input
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw};
  end

  // Sample window shifts once per tick
  always_ff @(posedge clk) begin
    if (rst)       samples_q <= '0;
    else if (tick) samples_q <= samples_d;
  end

  // Debounced level follows a full window of agreeing samples
  always_ff @(posedge clk) begin
    if (rst)         state_q <= 1'b0;
    else if (change) state_q <= samples_d[0];
  end

endmodule

// File: rtl/switch_irq.sv
// Wishbone slave exposing debounced switches, sticky edge flags, an
// interrupt mask and a control register; drives a level interrupt.
module switch_irq
  import switch_irq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int TICK_CYCLES = 100000
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [3:0]       wb_adr_i,
  input  logic [7:0]       wb_dat_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [7:0]       wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic [WIDTH-1:0] switch_i,
  output logic             irq_o
);

  localparam int               CNT_W    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             primed_q;
  logic             rise_en_q, fall_en_q;
  logic [WIDTH-1:0] state_w, stable_w, rise_w, fall_w;
  logic [WIDTH-1:0] evt_q, evt_d, mask_q, mask_d;
  logic             ack_q, irq_q;
  logic [7:0]       dat_q;
  logic             req, wr_edge, wr_mask, wr_ctrl;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic             unused_in;

  // Burst hints are ignored: every access is handled as a classic cycle
  assign unused_in = &{1'b0, wb_cti_i, wb_bte_i, wb_dat_i};

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  // A new request is only accepted while ack is low, giving 2-cycle accesses
  assign req     = wb_cyc_i && wb_stb_i && !ack_q;
  assign wr_edge = req && wb_we_i && (reg_base(wb_adr_i) == ADDR_EDGE);
  assign wr_mask = req && wb_we_i && (reg_base(wb_adr_i) == ADDR_MASK);
  assign wr_ctrl = req && wb_we_i && (reg_base(wb_adr_i) == ADDR_CTRL);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    localparam logic [1:0] LANE = 2'(gi / 8);
    logic lane_hit;
    logic wbit;

    assign lane_hit = (wb_adr_i[1:0] == LANE);
    assign wbit     = wb_dat_i[gi % 8];

    switch_debounce u_db (
      .clk      (wb_clk),
      .rst      (wb_rst),
      .tick     (tick),
      .primed   (primed_q),
      .raw      (switch_i[gi]),
      .state_o  (state_w[gi]),
      .stable_o (stable_w[gi]),
      .rise_o   (rise_w[gi]),
      .fall_o   (fall_w[gi])
    );

    // A new event overrides a same-cycle write-1-to-clear
    assign evt_d[gi]  = (evt_q[gi] & ~(wr_edge & lane_hit & wbit))
                      | (rise_w[gi] & rise_en_q)
                      | (fall_w[gi] & fall_en_q);
    assign mask_d[gi] = (wr_mask && lane_hit) ? wbit : mask_q[gi];
  end

  // Read mux: register contents as seen in the strobe-sample cycle
  always_comb begin
    rd_word = '0;
    case (reg_base(wb_adr_i))
      ADDR_STATE: rd_word = 32'(state_w);
      ADDR_EDGE:  rd_word = 32'(evt_q);
      ADDR_MASK:  rd_word = 32'(mask_q);
      default: begin
        rd_word[CTRL_RISE_EN] = rise_en_q;
        rd_word[CTRL_FALL_EN] = fall_en_q;
        rd_word[CTRL_PRIMED]  = primed_q;
      end
    endcase
    case (wb_adr_i[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  // Tick counter and the one-time priming flag
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (tick && (&stable_w)) primed_q <= 1'b1;
    end
  end

  // Register file: sticky edges, mask and control enables
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      evt_q     <= '0;
      mask_q    <= '0;
      rise_en_q <= 1'b0;
      fall_en_q <= 1'b0;
    end else begin
      evt_q  <= evt_d;
      mask_q <= mask_d;
      if (wr_ctrl && (wb_adr_i[1:0] == 2'd0)) begin
        rise_en_q <= wb_dat_i[CTRL_RISE_EN];
        fall_en_q <= wb_dat_i[CTRL_FALL_EN];
      end
    end
  end

  // Bus response: one-cycle ack with registered read data
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      if (req) dat_q <= rd_byte;
    end
  end

  // Interrupt lags EDGE/MASK by one cycle
  always_ff @(posedge wb_clk) begin
    if (wb_rst) irq_q <= 1'b0;
    else        irq_q <= |(evt_q & mask_q);
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_switch_irq.sv
// Scoreboard bench for switch_irq: directed scenarios plus random register
// traffic and switch patterns, checked against a register-level model.
module tb_switch_irq;

  localparam int          WIDTH  = 12;
  localparam int          TICK   = 4;
  localparam int          SETTLE = 2 + 4 * TICK + 2;
  localparam logic [31:0] WMASK  = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       adr = '0;
  logic [7:0]       dat_i = '0;
  logic             we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [2:0]       cti = '0;
  logic [1:0]       bte = '0;
  logic [7:0]       dat_o;
  logic             ack, err, rty, irq;
  logic [WIDTH-1:0] sw = '0;

  always #5 clk = ~clk;

  switch_irq #(.WIDTH(WIDTH), .TICK_CYCLES(TICK)) dut (
    .wb_clk   (clk),
    .wb_rst   (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty),
    .switch_i (sw),
    .irq_o    (irq)
  );

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  // Clock edges since reset release; ticks land on multiples of TICK
  always @(posedge clk) ncyc <= rst ? 0 : ncyc + 1;

  // Register-level model
  logic [31:0] m_state, m_edge, m_mask;
  bit          m_rise, m_fall, m_primed;
  int          prime_at;

  typedef struct {
    bit         is_rd;
    logic [3:0] a;
    logic [7:0] exp;
  } txn_t;
  txn_t sbq[$];
  logic irq_at_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset(input logic [WIDTH-1:0] held);
    m_state = '0; m_edge = '0; m_mask = '0;
    m_rise = 0; m_fall = 0; m_primed = 0;
    // Samples start at 0, so an all-zero input agrees after one tick
    prime_at = TICK * ((held == '0) ? 1 : 3);
  endfunction

  function automatic void model_prime();
    if (!m_primed && ncyc >= prime_at) begin
      m_primed = 1;
      m_state  = 32'(sw);
    end
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    case (a[3:2])
      2'd0:    r = m_state;
      2'd1:    r = m_edge;
      2'd2:    r = m_mask;
      default: r = {24'h0, m_primed, 5'h0, m_fall, m_rise};
    endcase
    return r[8*a[1:0] +: 8];
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
    logic [31:0] v, lm;
    v  = 32'(d) << (8 * a[1:0]);
    lm = 32'hFF << (8 * a[1:0]);
    case (a[3:2])
      2'd1: m_edge = m_edge & ~v;
      2'd2: m_mask = ((m_mask & ~lm) | v) & WMASK;
      2'd3: if (a[1:0] == 2'd0) begin m_rise = d[0]; m_fall = d[1]; end
      default: ;
    endcase
  endfunction

  function automatic void model_apply(input logic [WIDTH-1:0] v);
    logic [31:0] nv, rises, falls;
    nv    = 32'(v);
    rises = nv & ~m_state;
    falls = m_state & ~nv;
    m_edge  = m_edge | (m_rise ? rises : 32'h0) | (m_fall ? falls : 32'h0);
    m_state = nv;
  endfunction

  // One bus access; starts and ends on a falling edge with ack low
  task automatic bus(input bit wr, input logic [3:0] a, input logic [7:0] d);
    txn_t t;
    model_prime();
    t.is_rd = !wr;
    t.a     = a;
    t.exp   = model_read(a);
    sbq.push_back(t);
    adr = a; dat_i = d; we = wr; cyc = 1'b1; stb = 1'b1;
    cti = 3'($urandom); bte = 2'($urandom);
    @(posedge clk);
    if (wr) model_write(a, d);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_switches(input logic [WIDTH-1:0] v);
    sw = v;
    repeat (SETTLE) @(negedge clk);
    model_apply(v);
  endtask

  task automatic align_tick();
    while (ncyc % TICK != 0) @(negedge clk);
  endtask

  task automatic check_irq(input string name);
    check(name, {31'b0, irq}, {31'b0, |(m_edge & m_mask)});
  endtask

  // Monitor: every ack pops one expected transaction
  logic prev_ack = 1'b0;
  txn_t mt;
  always @(negedge clk) begin
    if (ack) begin
      check("ack_width", {31'b0, prev_ack}, 32'h0);
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_ack: got ack expected none");
      end else begin
        mt = sbq.pop_front();
        if (mt.is_rd) check($sformatf("read_%0h", mt.a), {24'h0, dat_o}, {24'h0, mt.exp});
        $display("txn %s adr=0x%0h data=0x%02h", mt.is_rd ? "rd" : "wr", mt.a, dat_o);
      end
      irq_at_ack = irq;
    end
    prev_ack = ack;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [WIDTH-1:0] nsw;
    logic             b;
    int               target;

    // Reset with switches low; every register byte reads back
    sw  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset(sw);
    check("reset_ack", {31'b0, ack}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_dat", {24'h0, dat_o}, 32'h0);
    check("tie_err_rty", {30'b0, err, rty}, 32'h0);
    for (int a = 0; a < 16; a++) bus(0, 4'(a), 8'h00);

    // Reset asserted together with a strobe: no ack may follow
    @(negedge clk);
    adr = 4'h0; cyc = 1'b1; stb = 1'b1; rst = 1'b1; sw = 12'h0A5;
    @(negedge clk);
    check("rst_ack_suppress", {31'b0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rst_ack_low", {31'b0, ack}, 32'h0);
    rst = 1'b0;
    model_reset(sw);

    // Priming with 0xA5 held; events enabled beforehand must not fire
    bus(0, 4'hC, 8'h00);
    bus(1, 4'hC, 8'h03);
    bus(0, 4'h0, 8'h00);
    while (ncyc < 3 * TICK + 1) @(negedge clk);
    bus(0, 4'h0, 8'h00);
    bus(0, 4'h1, 8'h00);
    bus(0, 4'hC, 8'h00);
    bus(0, 4'h4, 8'h00);
    check_irq("prime_irq");

    // Rise event on bit0 with mask, then clear by W1C
    bus(1, 4'hC, 8'h01);
    bus(1, 4'h8, 8'h01);
    set_switches(12'h0A4);
    bus(0, 4'h4, 8'h00);
    check_irq("fall_disabled_irq");
    set_switches(12'h0A5);
    bus(0, 4'h4, 8'h00);
    check_irq("rise_irq");
    bus(1, 4'h4, 8'h01);
    check("irq_lag", {31'b0, irq_at_ack}, 32'h1);
    check_irq("irq_after_clear");

    // Bounce on bit3 every tick for 10 ticks, then hold the new level
    b = m_state[3];
    for (int i = 0; i < 10; i++) begin
      align_tick();
      sw[3] = (i % 2 == 0) ? ~b : b;
      if (i == 5) bus(0, 4'h0, 8'h00);
      @(negedge clk);
    end
    bus(0, 4'h0, 8'h00);
    bus(0, 4'h4, 8'h00);
    align_tick();
    nsw = sw; nsw[3] = ~b;
    set_switches(nsw);
    bus(0, 4'h0, 8'h00);
    bus(0, 4'h4, 8'h00);
    bus(1, 4'h4, 8'h08);
    repeat (SETTLE) @(negedge clk);
    bus(0, 4'h4, 8'h00);

    // Set-wins: W1C of bit2 lands on the same edge as a bit2 fall event
    bus(1, 4'hC, 8'h03);
    nsw = sw; nsw[2] = 1'b0; set_switches(nsw);
    nsw = sw; nsw[2] = 1'b1; set_switches(nsw);
    bus(0, 4'h4, 8'h00);
    align_tick();
    nsw = sw; nsw[2] = 1'b0;
    sw = nsw;
    target = ncyc + 3 * TICK - 1;
    while (ncyc < target) @(negedge clk);
    bus(1, 4'h4, 8'h04);
    model_apply(nsw);
    bus(0, 4'h4, 8'h00);
    bus(0, 4'h0, 8'h00);

    // Bits at or above WIDTH ignore writes and read 0
    bus(1, 4'h9, 8'hFF);
    bus(0, 4'h9, 8'h00);
    bus(1, 4'hA, 8'hFF);
    bus(0, 4'hA, 8'h00);
    bus(0, 4'h2, 8'h00);
    bus(1, 4'h0, 8'hFF);
    bus(0, 4'h0, 8'h00);
    check_irq("irq_mask_wide");

    // Random register traffic and switch patterns
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0, 3: bus(0, 4'($urandom_range(0, 15)), 8'h00);
        1: begin
          bus(1, 4'($urandom_range(0, 15)), 8'($urandom));
          check_irq("rand_irq_wr");
        end
        default: begin
          set_switches(WIDTH'($urandom));
          check_irq("rand_irq_sw");
        end
      endcase
    end

    // Every issued access must have been acknowledged
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending accesses expected 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
